// File: rtl/hsv_core_pkg.sv
// hsv_core_pkg: shared core types; register masks cover x1..x31 (x0 never tracked).
package hsv_core_pkg;
  typedef logic [31:1] reg_mask;
  typedef enum logic {SB_RUN, SB_FLUSH} scoreboard_state_t;
endpackage

// File: rtl/hsv_core_issue_scoreboard_if.sv
// hsv_core_issue_scoreboard_if: masking-stage / commit / flush signals of the issue scoreboard.
interface hsv_core_issue_scoreboard_if #(
  parameter int CW = 4
);
  logic flush_req, valid_i, ready_i, commit_valid_i, stall_o, issue_o;
  hsv_core_pkg::reg_mask mask_i, rd_mask_i, commit_rd_mask_i, busy_o;
  logic [CW-1:0] inflight_o;
  modport master (
    output flush_req, valid_i, mask_i, rd_mask_i, ready_i, commit_valid_i, commit_rd_mask_i,
    input stall_o, issue_o, busy_o, inflight_o
  );
  modport slave (
    input flush_req, valid_i, mask_i, rd_mask_i, ready_i, commit_valid_i, commit_rd_mask_i,
    output stall_o, issue_o, busy_o, inflight_o
  );
endinterface

// File: rtl/hsv_core_issue_scoreboard.sv
// hsv_core_issue_scoreboard: register-hazard scoreboard, in-flight limiter and flush recovery.
// Define HSV_SCOREBOARD_BYPASS_EN to let a same-cycle commit release hazards and the full limit.
module hsv_core_issue_scoreboard
  import hsv_core_pkg::*;
#(
  parameter int MAX_INFLIGHT = 8,
  parameter int FLUSH_HOLD = 2
) (
  input logic clk_core,
  input logic rst_core_n,
  hsv_core_issue_scoreboard_if.slave sb
);
  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam int HW = FLUSH_HOLD > 1 ? $clog2(FLUSH_HOLD) : 1;
  scoreboard_state_t state_q, state_d;
  reg_mask busy_q, busy_d, clr, busy_eff;
  logic [CW-1:0] count_q, count_d;
  logic [HW-1:0] hold_q, hold_d;
  logic run, hazard, full, issue, dec;
  assign run = state_q == SB_RUN;
  assign clr = sb.commit_valid_i ? sb.commit_rd_mask_i : '0;
`ifdef HSV_SCOREBOARD_BYPASS_EN
  assign busy_eff = run ? busy_q & ~clr : busy_q;
  assign full = count_q == CW'(MAX_INFLIGHT) && !sb.commit_valid_i;
`else
  assign busy_eff = busy_q;
  assign full = count_q == CW'(MAX_INFLIGHT);
`endif
  assign hazard = |(sb.mask_i & busy_eff);
  assign issue = sb.valid_i & sb.ready_i & ~hazard & ~full & run & ~sb.flush_req;
  // a commit with nothing outstanding must not wrap the counter
  assign dec = sb.commit_valid_i && count_q != '0;
  assign sb.issue_o = issue;
  assign sb.stall_o = (sb.valid_i & ~issue) | ~run;
  assign sb.busy_o = busy_q;
  assign sb.inflight_o = count_q;
  always_comb begin
    state_d = state_q;
    busy_d = busy_q;
    count_d = count_q;
    hold_d = hold_q;
    if (sb.flush_req) begin
      state_d = SB_FLUSH;
      busy_d = '0;
      count_d = '0;
      hold_d = HW'(FLUSH_HOLD - 1);
    end else if (run) begin
      busy_d = (busy_q & ~clr) | (issue ? sb.rd_mask_i : '0);
      count_d = count_q + CW'(issue) - CW'(dec);
    end else if (hold_q == '0) begin
      state_d = SB_RUN;
    end else begin
      hold_d = hold_q - 1'b1;
    end
  end
  always_ff @(posedge clk_core) begin
    if (!rst_core_n) begin
      state_q <= SB_RUN;
      busy_q <= '0;
      count_q <= '0;
      hold_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q <= busy_d;
      count_q <= count_d;
      hold_q <= hold_d;
    end
  end
endmodule

// File: tb/tb_hsv_core_issue_scoreboard.sv
// tb_hsv_core_issue_scoreboard: directed checks of hazard, full, x0, flush and reset behaviour.
module tb_hsv_core_issue_scoreboard;
  import hsv_core_pkg::*;
  logic clk_core = 1'b0;
  logic rst_core_n = 1'b0;
  int total = 0;
  int passed = 0;
  hsv_core_issue_scoreboard_if #(.CW(4)) sb ();
  hsv_core_issue_scoreboard #(.MAX_INFLIGHT(8), .FLUSH_HOLD(2)) dut (
    .clk_core(clk_core),
    .rst_core_n(rst_core_n),
    .sb(sb)
  );
  always #5 clk_core = ~clk_core;

  function automatic reg_mask oh(input int r);
    reg_mask m;
    m = '0;
    m[r] = 1'b1;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic idle();
    sb.flush_req = 0; sb.valid_i = 0; sb.ready_i = 0; sb.commit_valid_i = 0;
    sb.mask_i = '0; sb.rd_mask_i = '0; sb.commit_rd_mask_i = '0;
  endtask

  task automatic drive(input reg_mask m, input reg_mask rd);
    sb.valid_i = 1; sb.ready_i = 1; sb.mask_i = m; sb.rd_mask_i = rd;
  endtask

  task automatic do_reset();
    rst_core_n = 0; idle(); tick(); rst_core_n = 1;
  endtask

  task automatic test_reset();
    rst_core_n = 0; idle();
    repeat (2) tick();
    rst_core_n = 1; #1;
    total++; if (sb.busy_o !== '0) $display("FAIL reset_busy: got %h want 0", sb.busy_o); else passed++;
    total++; if (sb.inflight_o !== 4'd0) $display("FAIL reset_inflight: got %0d want 0", sb.inflight_o); else passed++;
    total++; if (sb.stall_o !== 1'b0) $display("FAIL reset_stall: got %b want 0", sb.stall_o); else passed++;
    total++; if (sb.issue_o !== 1'b0) $display("FAIL reset_issue: got %b want 0", sb.issue_o); else passed++;
  endtask

  task automatic test_raw();
    do_reset();
    drive(oh(5), oh(5)); #1;
    total++; if (sb.issue_o !== 1'b1) $display("FAIL raw_first_issue: got %b want 1", sb.issue_o); else passed++;
    tick();
    total++; if (sb.busy_o !== oh(5)) $display("FAIL raw_busy: got %h want %h", sb.busy_o, oh(5)); else passed++;
    drive(oh(5) | oh(2), oh(2)); #1;
    total++; if (sb.issue_o !== 1'b0 || sb.stall_o !== 1'b1) $display("FAIL raw_hazard: got issue=%b stall=%b want 0/1", sb.issue_o, sb.stall_o); else passed++;
    tick();
    sb.commit_valid_i = 1; sb.commit_rd_mask_i = oh(5); #1;
`ifdef HSV_SCOREBOARD_BYPASS_EN
    total++; if (sb.issue_o !== 1'b1) $display("FAIL raw_bypass_issue: got %b want 1", sb.issue_o); else passed++;
    tick(); idle(); #1;
`else
    total++; if (sb.issue_o !== 1'b0) $display("FAIL raw_commit_cycle: got %b want 0", sb.issue_o); else passed++;
    tick(); sb.commit_valid_i = 0; #1;
    total++; if (sb.busy_o !== '0 || sb.inflight_o !== 4'd0) $display("FAIL raw_cleared: got busy=%h cnt=%0d want 0/0", sb.busy_o, sb.inflight_o); else passed++;
    total++; if (sb.issue_o !== 1'b1) $display("FAIL raw_late_issue: got %b want 1", sb.issue_o); else passed++;
    tick(); idle(); #1;
`endif
    total++; if (sb.busy_o !== oh(2) || sb.inflight_o !== 4'd1) $display("FAIL raw_after: got busy=%h cnt=%0d want %h/1", sb.busy_o, sb.inflight_o, oh(2)); else passed++;
  endtask

  task automatic test_same_bit();
    do_reset();
    drive(oh(7), oh(7)); tick();
    drive('0, oh(7)); sb.commit_valid_i = 1; sb.commit_rd_mask_i = oh(7); #1;
    total++; if (sb.issue_o !== 1'b1) $display("FAIL same_bit_issue: got %b want 1", sb.issue_o); else passed++;
    tick(); idle(); #1;
    total++; if (sb.busy_o !== oh(7) || sb.inflight_o !== 4'd1) $display("FAIL same_bit_state: got busy=%h cnt=%0d want %h/1", sb.busy_o, sb.inflight_o, oh(7)); else passed++;
  endtask

  task automatic test_full();
    reg_mask exp;
    do_reset();
    exp = '0;
    for (int i = 1; i <= 8; i++) begin
      drive(oh(i), oh(i)); #1;
      total++; if (sb.issue_o !== 1'b1) $display("FAIL full_fill_%0d: got %b want 1", i, sb.issue_o); else passed++;
      tick(); exp = exp | oh(i);
    end
    total++; if (sb.inflight_o !== 4'd8 || sb.busy_o !== exp) $display("FAIL full_state: got cnt=%0d busy=%h want 8/%h", sb.inflight_o, sb.busy_o, exp); else passed++;
    drive(oh(9), oh(9)); #1;
    total++; if (sb.issue_o !== 1'b0 || sb.stall_o !== 1'b1) $display("FAIL full_ninth: got issue=%b stall=%b want 0/1", sb.issue_o, sb.stall_o); else passed++;
    sb.commit_valid_i = 1; sb.commit_rd_mask_i = oh(1); #1;
`ifdef HSV_SCOREBOARD_BYPASS_EN
    total++; if (sb.issue_o !== 1'b1) $display("FAIL full_bypass_issue: got %b want 1", sb.issue_o); else passed++;
    tick(); idle(); #1;
`else
    total++; if (sb.issue_o !== 1'b0) $display("FAIL full_commit_cycle: got %b want 0", sb.issue_o); else passed++;
    tick(); sb.commit_valid_i = 0; #1;
    total++; if (sb.inflight_o !== 4'd7 || sb.issue_o !== 1'b1) $display("FAIL full_released: got cnt=%0d issue=%b want 7/1", sb.inflight_o, sb.issue_o); else passed++;
    tick(); idle(); #1;
`endif
    total++; if (sb.inflight_o !== 4'd8 || sb.busy_o !== ((exp & ~oh(1)) | oh(9))) $display("FAIL full_after: got cnt=%0d busy=%h want 8/%h", sb.inflight_o, sb.busy_o, (exp & ~oh(1)) | oh(9)); else passed++;
  endtask

  task automatic test_x0();
    do_reset();
    drive(oh(3), '0); #1;
    total++; if (sb.issue_o !== 1'b1) $display("FAIL x0_issue: got %b want 1", sb.issue_o); else passed++;
    tick(); idle(); #1;
    total++; if (sb.inflight_o !== 4'd1 || sb.busy_o !== '0) $display("FAIL x0_state: got cnt=%0d busy=%h want 1/0", sb.inflight_o, sb.busy_o); else passed++;
  endtask

  task automatic test_flush();
    reg_mask exp;
    do_reset();
    exp = '0;
    for (int i = 1; i <= 4; i++) begin
      drive(oh(i), oh(i)); tick(); exp = exp | oh(i);
    end
    idle(); #1;
    total++; if (sb.busy_o !== exp || sb.inflight_o !== 4'd4) $display("FAIL flush_pre: got busy=%h cnt=%0d want %h/4", sb.busy_o, sb.inflight_o, exp); else passed++;
    sb.flush_req = 1; drive(oh(10), oh(10)); #1;
    total++; if (sb.issue_o !== 1'b0 || sb.stall_o !== 1'b1) $display("FAIL flush_same_cycle: got issue=%b stall=%b want 0/1", sb.issue_o, sb.stall_o); else passed++;
    tick();
    sb.flush_req = 0; sb.valid_i = 0; sb.commit_valid_i = 1; sb.commit_rd_mask_i = oh(2); #1;
    total++; if (sb.busy_o !== '0 || sb.inflight_o !== 4'd0) $display("FAIL flush_cleared: got busy=%h cnt=%0d want 0/0", sb.busy_o, sb.inflight_o); else passed++;
    total++; if (sb.stall_o !== 1'b1) $display("FAIL flush_stall_idle: got %b want 1", sb.stall_o); else passed++;
    sb.valid_i = 1; #1;
    total++; if (sb.issue_o !== 1'b0) $display("FAIL flush_t1_issue: got %b want 0", sb.issue_o); else passed++;
    tick(); sb.commit_valid_i = 0; #1;
    total++; if (sb.issue_o !== 1'b0 || sb.stall_o !== 1'b1 || sb.inflight_o !== 4'd0) $display("FAIL flush_t2: got issue=%b stall=%b cnt=%0d want 0/1/0", sb.issue_o, sb.stall_o, sb.inflight_o); else passed++;
    tick();
    total++; if (sb.issue_o !== 1'b1 || sb.stall_o !== 1'b0) $display("FAIL flush_t3_issue: got issue=%b stall=%b want 1/0", sb.issue_o, sb.stall_o); else passed++;
    tick(); idle(); #1;
    total++; if (sb.inflight_o !== 4'd1 || sb.busy_o !== oh(10)) $display("FAIL flush_resume: got cnt=%0d busy=%h want 1/%h", sb.inflight_o, sb.busy_o, oh(10)); else passed++;
  endtask

  task automatic test_reset_in_flush();
    do_reset();
    drive(oh(3), oh(3)); tick();
    idle(); sb.flush_req = 1; tick();
    sb.flush_req = 0; #1;
    total++; if (sb.stall_o !== 1'b1) $display("FAIL rif_in_flush: got stall=%b want 1", sb.stall_o); else passed++;
    rst_core_n = 0; tick(); rst_core_n = 1; #1;
    total++; if (sb.busy_o !== '0 || sb.inflight_o !== 4'd0 || sb.stall_o !== 1'b0) $display("FAIL rif_state: got busy=%h cnt=%0d stall=%b want 0/0/0", sb.busy_o, sb.inflight_o, sb.stall_o); else passed++;
    drive(oh(4), oh(4)); #1;
    total++; if (sb.issue_o !== 1'b1) $display("FAIL rif_run_issue: got %b want 1", sb.issue_o); else passed++;
    tick(); idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_raw();
    test_same_bit();
    test_full();
    test_x0();
    test_flush();
    test_reset_in_flush();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/hsv_core_issue_scoreboard.md
# hsv_core_issue_scoreboard

Register-hazard scoreboard and issue controller that sits beside the issue masking stage. Tracks which architectural registers (x1..x31) have an in-flight writer, compares each incoming instruction's combined source/destination mask against that state, and either lets the instruction issue or holds the masking stage with `stall`. Also bounds the number of in-flight instructions and sequences the issue-side recovery after a pipeline flush.

## Interface
- `MAX_INFLIGHT`, 8: maximum outstanding issued-but-uncommitted instructions (≥1).
- `FLUSH_HOLD`, 2: cycles issue stays blocked after `flush_req` (≥1).

- `clk_core` in 1: core clock.
- `rst_core_n` in 1: reset. Synchronous and active-low.
- `flush_req` in 1: pipeline flush.
- `valid_i` in 1: masking stage holds a valid instruction.
- `mask_i` in `reg_mask` (31, [31:1]): rs1|rs2|rd mask from the masking stage.
- `rd_mask_i` in `reg_mask`: destination mask (all-zero for rd=x0).
- `ready_i` in 1: execution side accepts an instruction this cycle.
- `commit_valid_i` in 1: one instruction retires this cycle.
- `commit_rd_mask_i` in `reg_mask`: retiring destination mask (one-hot or zero).
- `stall_o` out 1: hold the masking stage.
- `issue_o` out 1: instruction issues this cycle.
- `busy_o` out `reg_mask`: current busy vector (registered).
- `inflight_o` out `$clog2(MAX_INFLIGHT+1)`: outstanding count (registered).

## Operation
- State `busy_q` (31 b), `count_q`, FSM `{RUN, FLUSH}`, hold counter `hold_q`.
- `hazard = |(mask_i & busy_eff)`; `busy_eff = busy_q` (see Configuration).
- `full = (count_q == MAX_INFLIGHT)`.
- `issue_o = valid_i & ready_i & ~hazard & ~full & (state==RUN) & ~flush_req`.
- `stall_o = valid_i & ~issue_o`; also 1 whenever state==FLUSH.
- RUN, per cycle: `busy_d = (busy_q & ~(commit_valid_i ? commit_rd_mask_i : 0)) | (issue_o ? rd_mask_i : 0)` — set wins over clear on the same bit.
- Count: +1 on issue, −1 on commit, both → unchanged. Commit at count 0: count stays 0, busy clear still applied.
- WAW covered because `mask_i` includes rd; one busy bit per register is sufficient.
- `flush_req` (any state): next cycle busy=0, count=0, state=FLUSH, `hold_q=FLUSH_HOLD-1`. Same-cycle issue is suppressed.
- FLUSH: commits ignored, no issue; `hold_q` decrements; at 0 → RUN. `flush_req` during FLUSH reloads `hold_q`.

## Timing
- Reset: `busy_o=0`, `inflight_o=0`, state RUN, `hold_q=0`; `issue_o`/`stall_o` follow their combinational equations (0 when `valid_i`=0).
- `issue_o`, `stall_o` combinational from inputs and registered state; no registered latency.
- Issue sets busy bit visible on `busy_o` and in hazard check next cycle.
- Commit clears busy bit next cycle (same cycle with bypass).
- After `flush_req` at cycle T, first possible issue at T+1+FLUSH_HOLD.
- Reset takes priority over flush; reset mid-FLUSH returns to RUN.

## Configuration
- `HSV_SCOREBOARD_BYPASS_EN`: defined → `busy_eff = busy_q & ~(commit_valid_i ? commit_rd_mask_i : 0)` in RUN, so a dependent instruction issues in the commit cycle; `full` also deasserts when `commit_valid_i` is high. Undefined → `busy_eff = busy_q`, `full` purely registered; dependent issue one cycle after commit.

## Structure
- `hsv_core_pkg`: `reg_mask` (existing), new `scoreboard_state_t` enum `{SB_RUN, SB_FLUSH}`.
- Single module; no sub-module needed.

## Test plan
- Issue rd=x5 (rd_mask=1<<5), next cycle mask with x5 → stall_o=1, issue_o=0; commit x5 → issues one cycle later (same cycle with bypass).
- Issue and commit x7 in same cycle with busy[7]=1 → busy[7] stays 1, count unchanged.
- Issue 8 independent instructions, ready_i=1 → inflight_o=8, 9th stalls; one commit → 9th issues.
- rd=x0 instruction (rd_mask=0) → issues, inflight+1, busy unchanged.
- busy=0x1E, count=4, flush_req at T → busy=0,count=0 at T+1; commits ignored; first issue at T+3 (FLUSH_HOLD=2).
- rst_core_n low during FLUSH with busy set → next cycle all outputs at reset values, RUN.
